button_events: RTL and testbench

Converts a debounced, synchronised push-button level into discrete user-interface events for the 7-segment clock: short press, long press and auto-repeat while held. It sits directly downstream of the button debouncer, one instance per button. Its one-cycle event pulses drive the time-setting logic, for example advancing hours or minutes.

---
 rtl/button_events.sv | 141 ++++++++++++++
 tb/tb_button_events.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//
// Turns a debounced, synchronised push-button level into one-cycle UI events:
// short press, long press and auto-repeat while held. One instance per button,
// placed directly after that button's debouncer.
//
// Parameters
//   LONG_PRESS_CYCLES  hold time for a long press (2 .. 2^24)
//   REPEAT_CYCLES      auto-repeat period once held (2 .. 2^24)
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_btn        debounced button level, 1 = pressed, synchronous to i_clk
//   i_repeat_en  allows o_repeat while in HELD
//   o_short      1-cycle pulse: released before the long-press threshold
//   o_long       1-cycle pulse: hold reached LONG_PRESS_CYCLES
//   o_repeat     1-cycle pulse every REPEAT_CYCLES while held after a long press
//   o_held       level: FSM is in PRESSED or HELD
//
// Handshake: there is none. i_btn / i_repeat_en are plain levels sampled every
// clock; the event outputs are registered strobes, valid for exactly the one
// cycle they are high, with no back-pressure from the consumer.
// -----------------------------------------------------------------------------
module button_events #(
  parameter int LONG_PRESS_CYCLES = 10_000_000,
  parameter int REPEAT_CYCLES     = 2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } state_e;

  // Terminal counts; both fit in 24 bits across the legal parameter range.
  localparam logic [23:0] LP_LAST = 24'(LONG_PRESS_CYCLES - 1);
  localparam logic [23:0] RP_LAST = 24'(REPEAT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [23:0] pcnt_q, pcnt_d;
  logic [23:0] rcnt_q, rcnt_d;
  logic        btn_q;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;
  logic        btn_rise;

  assign btn_rise = i_btn & ~btn_q;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    rcnt_d   = rcnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_rise) begin
          state_d = ST_PRESSED;
          pcnt_d  = '0;
        end
      end
      ST_PRESSED: begin
        // Release wins over the threshold so a press can never yield both
        // a short and a long event.
        if (!i_btn) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end else if (pcnt_q == LP_LAST) begin
          long_d  = 1'b1;
          rcnt_d  = '0;
          state_d = ST_HELD;
        end else begin
          pcnt_d = pcnt_q + 24'd1;
        end
      end
      ST_HELD: begin
        if (!i_btn) begin
          state_d = ST_IDLE;
        end else if (!i_repeat_en) begin
          // Holding the count at zero makes a later enable restart a full period.
          rcnt_d = '0;
        end else if (rcnt_q == RP_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    held_d = (state_d != ST_IDLE);
  end

  // btn_q resets to 1 so a button already down at reset release does not
  // look like a fresh press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      rcnt_q   <= '0;
      btn_q    <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      rcnt_q   <= rcnt_d;
      btn_q    <= i_btn;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_repeat = repeat_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//
// Directed bench for button_events with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4.
// Each vector row gives the inputs applied before a rising clock edge and the
// outputs {o_short, o_long, o_repeat, o_held} expected just after that edge.
// Reset-related corner cases are hand-written around the vector runs.
// -----------------------------------------------------------------------------
module tb_button_events;

  logic clk;
  logic rst_n;
  logic btn;
  logic en;
  logic o_short, o_long, o_repeat, o_held;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       btn;
    logic       en;
    logic [3:0] exp;
    string      tag;
  } vec_t;

  vec_t       vec_q[$];
  logic [3:0] exp_q[$];
  int         vec_idx = 0;

  button_events #(
    .LONG_PRESS_CYCLES(8),
    .REPEAT_CYCLES    (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn      (btn),
    .i_repeat_en(en),
    .o_short    (o_short),
    .o_long     (o_long),
    .o_repeat   (o_repeat),
    .o_held     (o_held)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic add(input logic b, input logic e, input int n,
                     input logic [3:0] exp, input string tag);
    vec_t v;
    v.btn = b;
    v.en  = e;
    v.exp = exp;
    v.tag = tag;
    for (int i = 0; i < n; i++) vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] got);
    logic [3:0] want;
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {short,long,repeat,held}=%b expected %b at %0t",
               name, got, want, $time);
    end
  endtask

  // Inputs change 1 time unit after an edge, outputs are sampled 1 unit after
  // the next edge.
  task automatic run_vecs();
    vec_t v;
    while (vec_q.size() > 0) begin
      v   = vec_q.pop_front();
      btn = v.btn;
      en  = v.en;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", v.tag, vec_idx), {o_short, o_long, o_repeat, o_held});
      vec_idx++;
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] want);
    exp_q.push_back(want);
    check(name, {o_short, o_long, o_repeat, o_held});
  endtask

  // Press of 8 cycles reaching HELD: E..E+7 held only, E+8 long.
  task automatic add_to_held(input logic e, input string tag);
    add(1'b1, e, 8, 4'b0001, tag);
    add(1'b1, e, 1, 4'b0101, tag);
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    en    = 1'b1;
    #12;
    check_now("reset_state", 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: 3-cycle press -> one short after R, held for 3 cycles
    add(1'b0, 1'b1, 2, 4'b0000, "s1_idle");
    add(1'b1, 1'b1, 3, 4'b0001, "s1_press");
    add(1'b0, 1'b1, 1, 4'b1000, "s1_release");
    add(1'b0, 1'b1, 2, 4'b0000, "s1_after");

    // 2: hold 21 edges with repeat enabled -> long E+8, repeat E+12/16/20
    add_to_held(1'b1, "s2_long");
    for (int r = 0; r < 3; r++) begin
      add(1'b1, 1'b1, 3, 4'b0001, "s2_wait");
      add(1'b1, 1'b1, 1, 4'b0011, "s2_repeat");
    end
    add(1'b0, 1'b1, 1, 4'b0000, "s2_release");
    add(1'b0, 1'b1, 2, 4'b0000, "s2_after");

    // 3: release sampled where pcnt == 7 -> short, never long
    add(1'b1, 1'b1, 8, 4'b0001, "s3_press");
    add(1'b0, 1'b1, 1, 4'b1000, "s3_release");
    add(1'b0, 1'b1, 3, 4'b0000, "s3_after");

    // minimum press: one cycle high
    add(1'b1, 1'b1, 1, 4'b0001, "min_press");
    add(1'b0, 1'b1, 1, 4'b1000, "min_release");
    add(1'b0, 1'b1, 2, 4'b0000, "min_after");

    // 5: HELD with enable low 10 cycles, then high -> repeat at F+3, F+7
    add_to_held(1'b0, "s5_long");
    add(1'b1, 1'b0, 10, 4'b0001, "s5_en_low");
    add(1'b1, 1'b1, 3, 4'b0001, "s5_en_wait");
    add(1'b1, 1'b1, 1, 4'b0011, "s5_repeat1");
    add(1'b1, 1'b1, 3, 4'b0001, "s5_wait2");
    add(1'b1, 1'b1, 1, 4'b0011, "s5_repeat2");
    add(1'b0, 1'b1, 1, 4'b0000, "s5_release");
    add(1'b0, 1'b1, 2, 4'b0000, "s5_after");
    run_vecs();

    // 4: button held through reset release is ignored until re-pressed
    btn = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("s4_in_reset", 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add(1'b1, 1'b1, 30, 4'b0000, "s4_held_thru_reset");
    add(1'b0, 1'b1, 1, 4'b0000, "s4_release");
    add(1'b1, 1'b1, 3, 4'b0001, "s4_repress");
    add(1'b0, 1'b1, 1, 4'b1000, "s4_short");
    add(1'b0, 1'b1, 1, 4'b0000, "s4_after");
    run_vecs();

    // 6: asynchronous reset between edges while in HELD
    add_to_held(1'b1, "s6_long");
    add(1'b1, 1'b1, 1, 4'b0001, "s6_held");
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    check_now("s6_async_reset", 4'b0000);
    @(posedge clk);
    #1;
    check_now("s6_reset_edge", 4'b0000);
    rst_n = 1'b1;
    add(1'b1, 1'b1, 20, 4'b0000, "s6_still_held");
    add(1'b0, 1'b1, 1, 4'b0000, "s6_release");
    add(1'b1, 1'b1, 1, 4'b0001, "s6_repress");
    add(1'b0, 1'b1, 1, 4'b1000, "s6_short");
    add(1'b0, 1'b1, 1, 4'b0000, "s6_after");
    run_vecs();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
